// File: rtl/mux_dw.sv
// Write-back data selector: picks link PC, load data or ALU result for the register file.
// Define MUX_DW_LOAD_EXT_EN to add sub-word load formatting (byte/halfword, signed/unsigned).
module mux_dw #(
   parameter int WIDTH     = 32,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     pc_inc,
   input  logic [WIDTH-1:0]     data_rd,
   input  logic [WIDTH-1:0]     alu_output,
   input  logic [1:0]           dw_sel,
   input  logic [1:0]           ld_size,
   input  logic                 ld_unsigned,
   input  logic [1:0]           byte_off,
   output logic [WIDTH-1:0]     dw,
   output logic [WIDTH-1:0]     dw_q,
   output logic                 sel_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      SEL_LINK = 2'b00,
      SEL_LOAD = 2'b01,
      SEL_ALU  = 2'b10,
      SEL_BAD  = 2'b11
   } dw_sel_e;

   logic [WIDTH-1:0] ld_data;

`ifdef MUX_DW_LOAD_EXT_EN
   logic [15:0] half_v;
   logic [7:0]  byte_v;
   logic        ext_bit;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path infers a latch.
      ld_data = data_rd;
      half_v  = byte_off[1] ? data_rd[31:16] : data_rd[15:0];
      byte_v  = data_rd[8*byte_off +: 8];
      ext_bit = 1'b0;
      case (ld_size)
         2'b01: begin
            ext_bit = ~ld_unsigned & half_v[15];
            ld_data = {{(WIDTH-16){ext_bit}}, half_v};
         end
         2'b10: begin
            ext_bit = ~ld_unsigned & byte_v[7];
            ld_data = {{(WIDTH-8){ext_bit}}, byte_v};
         end
         default: ld_data = data_rd;
      endcase
   end
`else
   assign ld_data = data_rd;

   // Load-format controls are dead in this build; this sink is optimised away.
   logic unused_ld_ctrl;
   assign unused_ld_ctrl = ^{ld_size, ld_unsigned, byte_off};
`endif

   always_comb begin
      dw      = '0;
      sel_err = 1'b0;
      case (dw_sel_e'(dw_sel))
         SEL_LINK: dw = pc_inc;
         SEL_LOAD: dw = ld_data;
         SEL_ALU:  dw = alu_output;
         default:  sel_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst) begin
         dw_q    <= '0;
         err_cnt <= '0;
      end else begin
         dw_q <= dw;
         if (sel_err && (err_cnt != {ERR_CNT_W{1'b1}}))
            err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mux_dw.sv
// Self-checking bench for mux_dw: vector table plus a dw_q scoreboard queue and err_cnt model.
// Load expectations follow MUX_DW_LOAD_EXT_EN when it is defined for the build.
module tb_mux_dw;

   localparam bit EXT = `ifdef MUX_DW_LOAD_EXT_EN 1'b1 `else 1'b0 `endif;
   localparam logic [31:0] LD_WORD = 32'h80FF7F01;

   logic        clk;
   logic        rst;
   logic [31:0] pc_inc, data_rd, alu_output;
   logic [1:0]  dw_sel, ld_size, byte_off;
   logic        ld_unsigned;
   logic [31:0] dw, dw_q;
   logic        sel_err;
   logic [7:0]  err_cnt;

   mux_dw #(.WIDTH(32), .ERR_CNT_W(8)) dut (
      .clk(clk), .rst(rst), .pc_inc(pc_inc), .data_rd(data_rd),
      .alu_output(alu_output), .dw_sel(dw_sel), .ld_size(ld_size),
      .ld_unsigned(ld_unsigned), .byte_off(byte_off), .dw(dw), .dw_q(dw_q),
      .sel_err(sel_err), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  sel;
      logic [31:0] pc;
      logic [31:0] rd;
      logic [31:0] alu;
      logic [1:0]  size;
      logic        uns;
      logic [1:0]  off;
      logic [31:0] exp_dw;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   int          model_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one vector, check the combinational outputs, then check the registered ones after the edge.
   task automatic step(input vec_t v);
      logic [31:0] exp_reg;
      dw_sel      = v.sel;
      pc_inc      = v.pc;
      data_rd     = v.rd;
      alu_output  = v.alu;
      ld_size     = v.size;
      ld_unsigned = v.uns;
      byte_off    = v.off;
      #1;
      check({v.name, " dw"}, dw, v.exp_dw);
      check({v.name, " sel_err"}, {31'b0, sel_err}, {31'b0, v.sel == 2'b11});
      exp_q.push_back(rst ? 32'h0 : v.exp_dw);
      if (rst) model_cnt = 0;
      else if (v.sel == 2'b11 && model_cnt < 255) model_cnt++;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard: queue empty", v.name);
      end else begin
         exp_reg = exp_q.pop_front();
         check({v.name, " dw_q"}, dw_q, exp_reg);
      end
      check({v.name, " err_cnt"}, {24'b0, err_cnt}, model_cnt[31:0]);
   endtask

   vec_t vecs[18];
   vec_t v;

   initial begin
      vecs[0]  = '{"link",      2'b00, 32'hF, 32'h9, 32'h5, 2'b00, 1'b0, 2'd0, 32'hF};
      vecs[1]  = '{"load",      2'b01, 32'hF, 32'h9, 32'h5, 2'b00, 1'b0, 2'd0, 32'h9};
      vecs[2]  = '{"alu",       2'b10, 32'hF, 32'h9, 32'h5, 2'b00, 1'b0, 2'd0, 32'h5};
      vecs[3]  = '{"seq00",     2'b00, 32'hF, 32'h9, 32'h5, 2'b00, 1'b0, 2'd0, 32'hF};
      vecs[4]  = '{"seq11",     2'b11, 32'hF, 32'h9, 32'h5, 2'b00, 1'b0, 2'd0, 32'h0};
      vecs[5]  = '{"seq10",     2'b10, 32'hF, 32'h9, 32'h5, 2'b00, 1'b0, 2'd0, 32'h5};
      vecs[6]  = '{"lb_s_off3", 2'b01, 32'h0, LD_WORD, 32'h0, 2'b10, 1'b0, 2'd3,
                   EXT ? 32'hFFFFFF80 : LD_WORD};
      vecs[7]  = '{"lb_s_off0", 2'b01, 32'h0, LD_WORD, 32'h0, 2'b10, 1'b0, 2'd0,
                   EXT ? 32'h00000001 : LD_WORD};
      vecs[8]  = '{"lh_s_off0", 2'b01, 32'h0, LD_WORD, 32'h0, 2'b01, 1'b0, 2'd0,
                   EXT ? 32'h00007F01 : LD_WORD};
      vecs[9]  = '{"lh_u_off2", 2'b01, 32'h0, LD_WORD, 32'h0, 2'b01, 1'b1, 2'd2,
                   EXT ? 32'h000080FF : LD_WORD};
      vecs[10] = '{"lb_u_off3", 2'b01, 32'h0, LD_WORD, 32'h0, 2'b10, 1'b1, 2'd3,
                   EXT ? 32'h00000080 : LD_WORD};
      vecs[11] = '{"lb_s_off1", 2'b01, 32'h0, LD_WORD, 32'h0, 2'b10, 1'b0, 2'd1,
                   EXT ? 32'h0000007F : LD_WORD};
      vecs[12] = '{"lb_s_off2", 2'b01, 32'h0, LD_WORD, 32'h0, 2'b10, 1'b0, 2'd2,
                   EXT ? 32'hFFFFFFFF : LD_WORD};
      vecs[13] = '{"lh_s_off2", 2'b01, 32'h0, LD_WORD, 32'h0, 2'b01, 1'b0, 2'd2,
                   EXT ? 32'hFFFF80FF : LD_WORD};
      vecs[14] = '{"lh_s_off3", 2'b01, 32'h0, LD_WORD, 32'h0, 2'b01, 1'b0, 2'd3,
                   EXT ? 32'hFFFF80FF : LD_WORD};
      vecs[15] = '{"lh_u_off1", 2'b01, 32'h0, LD_WORD, 32'h0, 2'b01, 1'b1, 2'd1,
                   EXT ? 32'h00007F01 : LD_WORD};
      vecs[16] = '{"lw_sz11",   2'b01, 32'h0, LD_WORD, 32'h0, 2'b11, 1'b0, 2'd1, LD_WORD};
      vecs[17] = '{"lw_sz00",   2'b01, 32'h0, LD_WORD, 32'h0, 2'b00, 1'b1, 2'd3, LD_WORD};

      // Reset with an illegal select: combinational outputs live, registers held at zero.
      rst = 1'b1;
      step('{"reset", 2'b11, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 2'd0, 32'h0});
      rst = 1'b0;
      for (int i = 0; i < 3; i++)
         step('{"idle_bad", 2'b11, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 2'd0, 32'h0});
      check("err_cnt after 3", {24'b0, err_cnt}, 32'd3);

      for (int i = 0; i < 18; i++) step(vecs[i]);

      // Saturation: 300 illegal cycles must pin the counter at 255.
      for (int i = 0; i < 300; i++)
         step('{"sat", 2'b11, 32'h1, 32'h2, 32'h3, 2'b00, 1'b0, 2'd0, 32'h0});
      check("err_cnt saturated", {24'b0, err_cnt}, 32'd255);

      // Reset wins over an illegal select, dw stays combinational, counting resumes after release.
      rst = 1'b1;
      step('{"rst_bad", 2'b11, 32'h1, 32'h2, 32'h3, 2'b00, 1'b0, 2'd0, 32'h0});
      check("err_cnt cleared", {24'b0, err_cnt}, 32'd0);
      step('{"rst_link", 2'b00, 32'hABCD, 32'h2, 32'h3, 2'b00, 1'b0, 2'd0, 32'hABCD});
      rst = 1'b0;
      step('{"resume", 2'b11, 32'h1, 32'h2, 32'h3, 2'b00, 1'b0, 2'd0, 32'h0});
      check("err_cnt resumed", {24'b0, err_cnt}, 32'd1);
      step('{"final_alu", 2'b10, 32'h1, 32'h2, 32'hDEAD_BEEF, 2'b00, 1'b0, 2'd0, 32'hDEAD_BEEF});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
